// File: rtl/wvb_rd_arbiter.sv
// Round-robin arbiter that shares one waveform read controller and its readout
// DPRAM between P_N_CHAN channel buffers, then hands each DPRAM to a consumer.
module wvb_rd_arbiter #(
   parameter int P_N_CHAN  = 24,
   parameter int P_HOLDOFF = 3
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                en,
   input  logic [P_N_CHAN-1:0] chan_mask,
   input  logic [P_N_CHAN-1:0] wvb_not_empty,
   input  logic                cfg_dpram_mode,
   output logic                rd_req,
   output logic [7:0]          rd_idx,
   output logic                rd_dpram_mode,
   input  logic                rd_ack,
   input  logic                rd_more,
   input  logic [15:0]         rd_dpram_len,
   output logic                dpram_rdy,
   output logic [15:0]         dpram_len,
   output logic                dpram_last,
   input  logic                dpram_done,
   output logic                busy,
   output logic [31:0]         evt_cnt,
   output logic [31:0]         frag_cnt
);

   localparam int unsigned HOLD_W = (P_HOLDOFF > 1) ? $clog2(P_HOLDOFF) : 1;
   localparam logic [7:0] LAST_RST = 8'(P_N_CHAN - 1);
   localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'((P_HOLDOFF > 0) ? P_HOLDOFF - 1 : 0);

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_ACK_DROP,
      S_XFER,
      S_HOLDOFF
   } state_t;

   state_t              state;
   logic [7:0]          last_chan;
   logic                more;
   logic [HOLD_W-1:0]   hold_cnt;

   logic [P_N_CHAN-1:0] cand;
   logic [7:0]          start;
   logic [7:0]          lo_idx;
   logic [7:0]          hi_idx;
   logic                lo_found;
   logic                hi_found;
   logic [7:0]          sel_idx;

   // Lowest eligible channel at or above start wins; otherwise wrap to the lowest overall.
   always_comb begin
      cand     = wvb_not_empty & chan_mask;
      start    = (last_chan == LAST_RST) ? 8'd0 : last_chan + 8'd1;
      lo_idx   = 8'd0;
      hi_idx   = 8'd0;
      lo_found = 1'b0;
      hi_found = 1'b0;
      for (int j = P_N_CHAN - 1; j >= 0; j--) begin
         if (cand[j]) begin
            lo_idx   = 8'(j);
            lo_found = 1'b1;
            if (8'(j) >= start) begin
               hi_idx   = 8'(j);
               hi_found = 1'b1;
            end
         end
      end
      sel_idx = hi_found ? hi_idx : lo_idx;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= S_IDLE;
         rd_req        <= 1'b0;
         rd_idx        <= 8'd0;
         rd_dpram_mode <= 1'b0;
         dpram_rdy     <= 1'b0;
         dpram_len     <= 16'd0;
         dpram_last    <= 1'b0;
         busy          <= 1'b0;
         evt_cnt       <= 32'd0;
         frag_cnt      <= 32'd0;
         last_chan     <= LAST_RST;
         more          <= 1'b0;
         hold_cnt      <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (en && lo_found) begin
                  rd_idx        <= sel_idx;
                  rd_dpram_mode <= cfg_dpram_mode;
                  rd_req        <= 1'b1;
                  busy          <= 1'b1;
                  state         <= S_REQ;
               end
            end
            S_REQ: begin
               if (rd_ack) begin
                  dpram_len <= rd_dpram_len;
                  more      <= rd_more;
                  rd_req    <= 1'b0;
                  state     <= S_ACK_DROP;
               end
            end
            S_ACK_DROP: begin
               if (!rd_ack) begin
                  dpram_rdy  <= 1'b1;
                  dpram_last <= !more;
                  state      <= S_XFER;
               end
            end
            S_XFER: begin
               if (dpram_done) begin
                  dpram_rdy  <= 1'b0;
                  dpram_last <= 1'b0;
                  frag_cnt   <= frag_cnt + 32'd1;
                  if (more) begin
                     // Same channel and mode continue into the next DPRAM.
                     rd_req <= 1'b1;
                     state  <= S_REQ;
                  end else begin
                     evt_cnt   <= evt_cnt + 32'd1;
                     last_chan <= rd_idx;
                     hold_cnt  <= HOLD_LOAD;
                     if (P_HOLDOFF == 0) begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                     end else begin
                        state <= S_HOLDOFF;
                     end
                  end
               end
            end
            S_HOLDOFF: begin
               if (hold_cnt == '0) begin
                  busy  <= 1'b0;
                  state <= S_IDLE;
               end else begin
                  hold_cnt <= hold_cnt - HOLD_W'(1);
               end
            end
            default: begin
               rd_req <= 1'b0;
               busy   <= 1'b0;
               state  <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_wvb_rd_arbiter.sv
// Directed bench for wvb_rd_arbiter: the bench plays both the read controller
// and the DPRAM consumer, and compares against hand-computed values.
module tb_wvb_rd_arbiter;

   localparam int N = 24;

   logic          clk = 1'b0;
   logic          rst;
   logic          en;
   logic [N-1:0]  chan_mask;
   logic [N-1:0]  wvb_not_empty;
   logic          cfg_dpram_mode;
   logic          rd_req;
   logic [7:0]    rd_idx;
   logic          rd_dpram_mode;
   logic          rd_ack;
   logic          rd_more;
   logic [15:0]   rd_dpram_len;
   logic          dpram_rdy;
   logic [15:0]   dpram_len;
   logic          dpram_last;
   logic          dpram_done;
   logic          busy;
   logic [31:0]   evt_cnt;
   logic [31:0]   frag_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   wvb_rd_arbiter #(.P_N_CHAN(N), .P_HOLDOFF(3)) dut (
      .clk            (clk),
      .rst            (rst),
      .en             (en),
      .chan_mask      (chan_mask),
      .wvb_not_empty  (wvb_not_empty),
      .cfg_dpram_mode (cfg_dpram_mode),
      .rd_req         (rd_req),
      .rd_idx         (rd_idx),
      .rd_dpram_mode  (rd_dpram_mode),
      .rd_ack         (rd_ack),
      .rd_more        (rd_more),
      .rd_dpram_len   (rd_dpram_len),
      .dpram_rdy      (dpram_rdy),
      .dpram_len      (dpram_len),
      .dpram_last     (dpram_last),
      .dpram_done     (dpram_done),
      .busy           (busy),
      .evt_cnt        (evt_cnt),
      .frag_cnt       (frag_cnt)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_rd_req"},     32'(rd_req),        32'd0);
      check({tag, "_rd_idx"},     32'(rd_idx),        32'd0);
      check({tag, "_mode"},       32'(rd_dpram_mode), 32'd0);
      check({tag, "_dpram_rdy"},  32'(dpram_rdy),     32'd0);
      check({tag, "_dpram_len"},  32'(dpram_len),     32'd0);
      check({tag, "_dpram_last"}, 32'(dpram_last),    32'd0);
      check({tag, "_busy"},       32'(busy),          32'd0);
      check({tag, "_evt_cnt"},    evt_cnt,            32'd0);
      check({tag, "_frag_cnt"},   frag_cnt,           32'd0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic wait_req(input int lim, output bit got, output int n);
      got = 1'b0;
      n   = 0;
      for (int i = 1; i <= lim; i++) begin
         @(negedge clk);
         if (rd_req) begin
            got = 1'b1;
            n   = i;
            break;
         end
      end
   endtask

   // Serve one DPRAM: ack with len/more, hold ack, then act as the consumer.
   task automatic serve_frag(input string tag, input logic [15:0] len, input bit more,
                             input int ack_hold, input int done_dly,
                             input logic [7:0] exp_idx, input bit exp_last,
                             input bit stop_in_xfer);
      bit got;
      int unstable;
      check({tag, "_idx"},  32'(rd_idx), 32'(exp_idx));
      check({tag, "_busy"}, 32'(busy),   32'd1);
      rd_ack       = 1'b1;
      rd_dpram_len = len;
      rd_more      = more;
      @(negedge clk);
      check({tag, "_req_drop"}, 32'(rd_req), 32'd0);
      unstable = 0;
      for (int i = 0; i < ack_hold; i++) begin
         @(negedge clk);
         if (dpram_rdy !== 1'b0 || rd_req !== 1'b0) unstable++;
      end
      check({tag, "_rdy_before_ack_drop"}, 32'(unstable), 32'd0);
      rd_ack = 1'b0;
      got = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (dpram_rdy) begin
            got = 1'b1;
            break;
         end
      end
      rd_dpram_len = 16'hDEAD;
      rd_more      = !more;
      check({tag, "_rdy_seen"}, 32'(got),        32'd1);
      check({tag, "_len"},      32'(dpram_len),  32'(len));
      check({tag, "_last"},     32'(dpram_last), 32'(exp_last));
      if (stop_in_xfer) return;
      unstable = 0;
      for (int i = 0; i < done_dly; i++) begin
         @(negedge clk);
         if (dpram_rdy !== 1'b1 || dpram_len !== len || dpram_last !== exp_last) unstable++;
      end
      check({tag, "_hold_stable"}, 32'(unstable), 32'd0);
      dpram_done = 1'b1;
      @(negedge clk);
      dpram_done = 1'b0;
      check({tag, "_rdy_drop"},  32'(dpram_rdy),  32'd0);
      check({tag, "_last_drop"}, 32'(dpram_last), 32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog timeout checks=%0d", n_checks);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] rr_exp [4];
      logic [7:0] mk_exp [3];
      bit got;
      int n;

      rr_exp = '{8'd0, 8'd4, 8'd0, 8'd4};
      mk_exp = '{8'd1, 8'd23, 8'd1};

      rst            = 1'b1;
      en             = 1'b1;
      chan_mask      = '1;
      wvb_not_empty  = 24'h000011;
      cfg_dpram_mode = 1'b0;
      rd_ack         = 1'b0;
      rd_more        = 1'b0;
      rd_dpram_len   = 16'd0;
      dpram_done     = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_vals("por");

      // Round-robin over ch0 and ch4.
      rst = 1'b0;
      for (int k = 0; k < 4; k++) begin
         wait_req(20, got, n);
         check("rr_req", 32'(got), 32'd1);
         serve_frag("rr", 16'h0040, 1'b0, 0, 0, rr_exp[k], 1'b1, 1'b0);
         check("rr_evt", evt_cnt, 32'(k + 1));
      end

      // Masked selection: only ch1 and ch23 are eligible.
      wvb_not_empty = 24'hFFFFFF;
      chan_mask     = 24'h800002;
      do_reset();
      for (int k = 0; k < 3; k++) begin
         wait_req(20, got, n);
         check("mask_req", 32'(got), 32'd1);
         serve_frag("mask", 16'h0010, 1'b0, 0, 2, mk_exp[k], 1'b1, 1'b0);
      end

      // Multi-DPRAM event on ch8; mid-event input changes must be ignored.
      wvb_not_empty  = 24'h000100;
      chan_mask      = '1;
      cfg_dpram_mode = 1'b1;
      do_reset();
      wait_req(20, got, n);
      check("m0_req", 32'(got), 32'd1);
      check("m0_mode", 32'(rd_dpram_mode), 32'd1);
      serve_frag("m0", 16'd2048, 1'b1, 5, 20, 8'd8, 1'b0, 1'b0);
      wvb_not_empty  = 24'h000001;
      cfg_dpram_mode = 1'b0;
      wait_req(20, got, n);
      check("m1_req", 32'(got), 32'd1);
      check("m1_mode", 32'(rd_dpram_mode), 32'd1);
      serve_frag("m1", 16'd2048, 1'b1, 0, 0, 8'd8, 1'b0, 1'b0);
      wait_req(20, got, n);
      check("m2_req", 32'(got), 32'd1);
      check("m2_mode", 32'(rd_dpram_mode), 32'd1);
      serve_frag("m2", 16'd300, 1'b0, 0, 3, 8'd8, 1'b1, 1'b0);
      check("m_frag_cnt", frag_cnt, 32'd3);
      check("m_evt_cnt",  evt_cnt,  32'd1);

      // Holdoff spacing and enable gating on a single channel.
      wvb_not_empty  = 24'h000020;
      cfg_dpram_mode = 1'b0;
      do_reset();
      wait_req(20, got, n);
      check("h0_req", 32'(got), 32'd1);
      serve_frag("h0", 16'h0008, 1'b0, 0, 0, 8'd5, 1'b1, 1'b0);
      wait_req(20, got, n);
      check("h1_req", 32'(got), 32'd1);
      check("h_gap_cycles", 32'(n), 32'd4);
      en = 1'b0;
      serve_frag("h1", 16'h0008, 1'b0, 0, 0, 8'd5, 1'b1, 1'b0);
      check("h_evt_cnt", evt_cnt, 32'd2);
      wait_req(20, got, n);
      check("h_no_req_en0", 32'(got), 32'd0);
      check("h_idle_busy", 32'(busy), 32'd0);
      en = 1'b1;
      wait_req(10, got, n);
      check("h_req_en1", 32'(got), 32'd1);

      // Reset while ch11 is in S_XFER; next grant restarts from the lowest channel.
      wvb_not_empty = 24'h000C00;
      do_reset();
      wait_req(20, got, n);
      check("r0_req", 32'(got), 32'd1);
      serve_frag("r0", 16'h0020, 1'b0, 0, 0, 8'd10, 1'b1, 1'b0);
      wait_req(20, got, n);
      check("r1_req", 32'(got), 32'd1);
      serve_frag("r1", 16'h0020, 1'b0, 0, 0, 8'd11, 1'b1, 1'b1);
      rst = 1'b1;
      @(negedge clk);
      check_reset_vals("mid");
      rst = 1'b0;
      wait_req(20, got, n);
      check("r_after_req", 32'(got), 32'd1);
      check("r_after_idx", 32'(rd_idx), 32'd10);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/wvb_rd_arbiter.md
Name: wvb_rd_arbiter

Overview:
- Round-robin scheduler that shares one format-0 waveform read controller, and its single readout DPRAM, between N channel waveform buffers.
- Picks the next non-empty, enabled channel and drives the read controller's req/idx handshake.
- Hands each filled DPRAM to the downstream consumer with a rdy/done handshake.
- In multi-DPRAM mode, re-requests the same channel until the event is complete.

Parameters:
- P_N_CHAN, 24, number of channel waveform buffers (1..256).
- P_HOLDOFF, 3, idle cycles after each event completes before re-scanning, so wvb_not_empty can settle after rddone.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- en  in  1  arbiter enable; sampled only in S_IDLE
- chan_mask  in  P_N_CHAN  per-channel enable
- wvb_not_empty  in  P_N_CHAN  per-channel buffer has an event
- cfg_dpram_mode  in  1  0 = truncate at one DPRAM, 1 = span DPRAMs
- rd_req  out  1  request to read controller
- rd_idx  out  8  selected channel (also drives external hdr/data mux)
- rd_dpram_mode  out  1  mode latched for the current event
- rd_ack  in  1  read controller ack
- rd_more  in  1  read controller: event continues in next DPRAM
- rd_dpram_len  in  16  DPRAM length in 16-bit words, valid while rd_ack=1
- dpram_rdy  out  1  DPRAM filled, ready for consumer
- dpram_len  out  16  latched length, valid while dpram_rdy=1
- dpram_last  out  1  this DPRAM ends the event
- dpram_done  in  1  consumer finished reading DPRAM (1-cycle pulse)
- busy  out  1  state != S_IDLE
- evt_cnt  out  32  events completed, wraps
- frag_cnt  out  32  DPRAMs handed off, wraps

Behaviour:
- Reset: rst synchronous, active-high; clock clk. Applies at any time, including mid-event.
- Reset values: rd_req, dpram_rdy, dpram_last, busy, rd_dpram_mode = 0; rd_idx, dpram_len, evt_cnt, frag_cnt = 0; last_chan = P_N_CHAN-1, so the first search starts at channel 0; holdoff counter = 0; state = S_IDLE.
- The read controller is not reset by this block. After a mid-event reset, system reset must reset both blocks.
- States: S_IDLE, S_REQ, S_ACK_DROP, S_XFER, S_HOLDOFF.
- S_IDLE:
  - Eligible channels: cand = wvb_not_empty & chan_mask.
  - If en and cand != 0: select the first set bit of cand searching upward from (last_chan+1) mod P_N_CHAN, wrapping.
  - Latch rd_idx = selected channel and rd_dpram_mode = cfg_dpram_mode; go to S_REQ.
  - Selection completes in one cycle, so rd_req asserts on the next cycle.
- S_REQ:
  - rd_req = 1, held until rd_ack is seen.
  - On rd_ack=1: latch dpram_len = rd_dpram_len and more = rd_more; drop rd_req in the next cycle; go to S_ACK_DROP.
- S_ACK_DROP:
  - rd_req = 0; wait for rd_ack = 0.
  - Then dpram_rdy = 1 and dpram_last = !more; go to S_XFER.
  - rd_req must be low for at least one cycle before any re-request.
- S_XFER:
  - Hold dpram_rdy, dpram_len and dpram_last stable until dpram_done.
  - On dpram_done: dpram_rdy = 0, dpram_last = 0, frag_cnt += 1.
  - If more: go to S_REQ with the same rd_idx and rd_dpram_mode. en, chan_mask and cfg changes are ignored mid-event.
  - Else: evt_cnt += 1, last_chan = rd_idx, load the holdoff counter, go to S_HOLDOFF.
  - dpram_done outside S_XFER is ignored.
- S_HOLDOFF: count P_HOLDOFF cycles, then go to S_IDLE. With P_HOLDOFF = 0, go straight to S_IDLE.
- Single eligible channel: it is re-selected every event (no starvation logic needed).
- Masking: clearing chan_mask or en mid-event does not abort the event; it affects only the next selection.
- rd_ack asserted outside S_REQ/S_ACK_DROP: ignored.
- Counters wrap from 2^32-1 to 0.
- rd_idx is zero-extended to 8 bits.

Test Plan:
- Round-robin:
  - Stimulus: not_empty = 0x000011 (ch0, ch4), mask all ones, mode 0, controller model acks with len = 0x0040 and more = 0.
  - Required: grants in order 0, 4, 0, 4; dpram_len = 0x0040; dpram_last = 1; evt_cnt increments once per event.
- Mask:
  - Stimulus: not_empty = 0xFFFFFF, chan_mask = 0x800002.
  - Required: rd_idx alternates 1, 23, 1; channels 0 and 2–22 are never granted.
- Multi-DPRAM:
  - Stimulus: mode 1, model returns more = 1, 1, 0 with len 2048, 2048, 300.
  - Required: three dpram_rdy handoffs, all with the same rd_idx; dpram_last = 0, 0, 1; frag_cnt = 3; evt_cnt = 1.
- Handshake timing:
  - Stimulus: model delays ack drop by 5 cycles; consumer delays done by 20 cycles.
  - Required: rd_req low within 1 cycle of ack; dpram_rdy asserts only after ack = 0; dpram_rdy and dpram_len stable until done.
- Holdoff / enable:
  - Stimulus: P_HOLDOFF = 3, single channel continuously not_empty; then deassert en mid-event.
  - Required: exactly 3 idle cycles plus the 1-cycle select before the next rd_req; the in-flight event completes; no new rd_req while en = 0.
- Reset mid-event:
  - Stimulus: rst during S_XFER.
  - Required: next cycle all outputs are at reset values and state = S_IDLE; the first grant after reset is the lowest eligible channel.
